// File: rtl/shift_rx_pkg.sv
// Shared types and sizing for the shift_rx serial frame receiver.
// The optional parity feature is selected with SHIFT_RX_PARITY_EN.
package shift_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam int unsigned RX_WIDTH = 4;
  localparam int unsigned RX_CNT_W = $clog2(RX_WIDTH + 1);

endpackage

// File: rtl/rx_shreg.sv
// Right-shifting receive register: the serial bit enters at the MSB,
// so after WIDTH shifts the first bit received sits in bit 0.
module rx_shreg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {din, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_rx.sv
// LSB-first serial frame receiver with a one-entry valid/ready word buffer.
// Define SHIFT_RX_PARITY_EN to add an even-parity bit, the PARITY state and ParErr.
module shift_rx
  import shift_rx_pkg::*;
#(
  parameter int unsigned WIDTH = RX_WIDTH
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             w,
  input  logic             wv,
  output logic [WIDTH-1:0] Q,
  output logic             Qv,
  input  logic             Qr,
  output logic             FrameErr,
`ifdef SHIFT_RX_PARITY_EN
  output logic             ParErr,
`endif
  output logic             Overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  rx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sh;
  logic             shift_c;
  logic             good_c;
`ifdef SHIFT_RX_PARITY_EN
  logic             par_bad;
`endif

  assign shift_c = wv && (state == DATA);

`ifdef SHIFT_RX_PARITY_EN
  assign good_c = wv && (state == STOP) && w && !par_bad;
`else
  assign good_c = wv && (state == STOP) && w;
`endif

  rx_shreg #(.WIDTH(WIDTH)) u_shreg (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .shift_en (shift_c),
    .din      (w),
    .q        (sh)
  );

  // Frame FSM, bit counter, output buffer and flags.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      Q        <= '0;
      Qv       <= 1'b0;
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      par_bad  <= 1'b0;
      ParErr   <= 1'b0;
`endif
    end else begin
      FrameErr <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      ParErr   <= 1'b0;
`endif

      // A loading word takes priority over a pure consume, so Qv has no bubble.
      if (good_c) begin
        if (!Qv || Qr) begin
          Q  <= sh;
          Qv <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (Qv && Qr) begin
        Qv <= 1'b0;
      end

      if (wv) begin
        case (state)
          IDLE: begin
            if (!w) begin
              cnt   <= '0;
              state <= DATA;
            end
          end
          DATA: begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SHIFT_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef SHIFT_RX_PARITY_EN
          PARITY: begin
            par_bad <= w ^ (^sh);
            state   <= STOP;
          end
`endif
          STOP: begin
            state <= IDLE;
            if (!w) begin
              FrameErr <= 1'b1;
            end
`ifdef SHIFT_RX_PARITY_EN
            else if (par_bad) begin
              ParErr <= 1'b1;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
